b13_anybit_dec: RTL and testbench
=================================

# b13_anybit_dec

Parameterized sequential binary-to-one-hot decoder: the receive-side counterpart of the team's any-bit priority encoder. It accepts a SEL_SIZE-bit code over a valid/ready handshake and drives the matching one-hot line of a 2^SEL_SIZE-bit output for a programmable number of cycles. Each pulse is followed by a programmable idle gap. It sits downstream of the encoder, or of any block producing an index, to regenerate strobes or select lines.

## Interface
Parameters:
- SEL_SIZE, 4, width of the input code; the only parameter normally configured.
- OUT_SIZE, 1<<SEL_SIZE, width of the one-hot output; derived, not overridden.
- HOLD, 4, number of cycles a decoded line stays asserted; legal range 1..65535.
- GAP, 1, number of all-zero cycles after each pulse before the next accept; legal range 0..65535.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  block enable; low forces idle and zero output.
- in_valid  input  1  in_code is valid this cycle.
- in_ready  output  1  block can accept a code this cycle.
- in_code  input  SEL_SIZE  index of the line to assert.
- dec_out  output  OUT_SIZE  registered one-hot output; all zero when not driving.
- busy  output  1  high in DRIVE or GAP.
- done  output  1  one-cycle pulse during the last DRIVE cycle of a pulse.

## Operation
- States: IDLE, DRIVE, GAP. There is one 16-bit down-counter `cnt` and one SEL_SIZE-bit code register.
- IDLE:
  - in_ready = enable. dec_out = 0.
  - Accept when in_valid && in_ready: latch in_code, load cnt = HOLD-1, go to DRIVE.
- DRIVE:
  - dec_out = 1 << latched code. Exactly one bit is high.
  - cnt decrements each cycle.
  - When cnt == 0, done = 1 and the FSM leaves: to GAP with cnt = GAP-1 if GAP > 0, otherwise to IDLE.
- GAP:
  - dec_out = 0. cnt decrements.
  - When cnt == 0, go to IDLE.
- in_ready is low in DRIVE and GAP. in_valid is ignored there, and no code is queued.
- Every code value 0..OUT_SIZE-1 is legal, so there is no out-of-range case. Code 0 drives dec_out[0]; code OUT_SIZE-1 drives the MSB.
- enable low in any state: at the next edge the FSM goes to IDLE and dec_out becomes 0. done is not asserted for an aborted pulse. in_ready goes low combinationally.
- enable low in the same cycle as done: done is still asserted (it is combinational from the state) and the FSM goes to IDLE.
- busy = (state != IDLE). done = (state == DRIVE) && (cnt == 0).
- dec_out, state, cnt and the code register are flops. in_ready, busy and done are decoded from them plus enable.

## Timing
- Reset values: state = IDLE, cnt = 0, code register = 0, dec_out = 0, busy = 0, done = 0. in_ready = enable.
- Reset asserted mid-pulse clears dec_out immediately (asynchronously) without waiting for a clock edge.
- Handshake: a transfer occurs on the rising edge where in_valid && in_ready.
- Latency: dec_out shows the decoded line starting the cycle after the accepting edge.
- Pulse width: dec_out is high for exactly HOLD cycles. done is high in the HOLD-th cycle.
- Idle gap: dec_out is zero for exactly GAP cycles, then in_ready rises in the following cycle.
- Maximum throughput: one code per HOLD+GAP+1 cycles. With GAP = 0 this is HOLD+1, because one IDLE cycle is mandatory.
- HOLD = 1: DRIVE lasts one cycle, and done coincides with the first and only output cycle.

## Test plan
- Reset check: assert rst mid-DRIVE (SEL_SIZE=4, code 9) -> dec_out = 0x0000, busy = 0 and done = 0 immediately. After release, in_ready = 1 with enable = 1.
- Single decode: SEL_SIZE=4, HOLD=4, GAP=1; present code 5 at edge 0 ->
  - dec_out = 0x0020 for cycles 1–4 and done = 1 in cycle 4.
  - dec_out = 0 in cycle 5; in_ready = 1 in cycle 6.
- Boundaries and sweep:
  - code 0 -> dec_out = 0x0001; code 15 -> dec_out = 0x8000.
  - Sweep all 16 codes; exactly one bit is high each time and equals 1<<code.
- Back-to-back with backpressure: HOLD=2, GAP=0, in_valid held high with codes 3 then 7 ->
  - in_ready = 0 during cycles 1–2, so code 7 is not accepted early.
  - Code 7 is accepted at edge 3; dec_out = 0x0080 in cycles 4–5.
- Abort: HOLD=8, accept code 2, then drop enable in cycle 3 -> dec_out = 0 from cycle 4, no done pulse, state IDLE. Re-enabling with code 1 produces a full 8-cycle 0x0002 pulse.
- Minimum hold: HOLD=1, GAP=0, code 12 -> dec_out = 0x1000 for one cycle with done = 1 in that cycle, then in_ready = 1 in the next cycle.

Source files
------------

// File: rtl/b13_anybit_dec_if.sv
// Handshake and output bundle for the any-bit one-hot decoder.
// The master drives codes in; the slave (decoder) drives ready and the decoded lines.
interface b13_anybit_dec_if #(
  parameter int SEL_SIZE = 4,
  parameter int OUT_SIZE = 1 << SEL_SIZE
);
  logic                enable;
  logic                in_valid;
  logic                in_ready;
  logic [SEL_SIZE-1:0] in_code;
  logic [OUT_SIZE-1:0] dec_out;
  logic                busy;
  logic                done;

  modport master (
    output enable, in_valid, in_code,
    input  in_ready, dec_out, busy, done
  );

  modport slave (
    input  enable, in_valid, in_code,
    output in_ready, dec_out, busy, done
  );
endinterface

// File: rtl/b13_anybit_dec.sv
// Sequential binary-to-one-hot decoder: accepts a code, drives its line for HOLD
// cycles, then stays quiet for GAP cycles before accepting the next code.
module b13_anybit_dec #(
  parameter int SEL_SIZE = 4,
  parameter int OUT_SIZE = 1 << SEL_SIZE,
  parameter int HOLD     = 4,
  parameter int GAP      = 1
) (
  input  logic              clk,
  input  logic              rst,
  b13_anybit_dec_if.slave   io_bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_GAP} state_t;

  localparam logic [15:0] HOLD_M1 = 16'(HOLD - 1);
  localparam logic [15:0] GAP_M1  = (GAP > 0) ? 16'(GAP - 1) : 16'd0;

  state_t              r_state;
  state_t              w_next_state;
  logic [15:0]         r_cnt;
  logic [15:0]         w_next_cnt;
  logic [SEL_SIZE-1:0] r_code;
  logic [SEL_SIZE-1:0] w_next_code;
  logic [OUT_SIZE-1:0] r_dec_out;
  logic [OUT_SIZE-1:0] w_next_dec;
  logic                w_cnt_zero;

  assign w_cnt_zero = (r_cnt == 16'd0);

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_code  = r_code;
    w_next_dec   = '0;

    unique case (r_state)
      ST_IDLE: begin
        if (io_bus.in_valid && io_bus.enable) begin
          w_next_code  = io_bus.in_code;
          w_next_cnt   = HOLD_M1;
          w_next_state = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (w_cnt_zero) begin
          if (GAP > 0) begin
            w_next_state = ST_GAP;
            w_next_cnt   = GAP_M1;
          end else begin
            w_next_state = ST_IDLE;
          end
        end else begin
          w_next_cnt = r_cnt - 16'd1;
        end
      end
      ST_GAP: begin
        if (w_cnt_zero) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_cnt = r_cnt - 16'd1;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_cnt   = '0;
      end
    endcase

    // Dropping enable abandons any pulse in flight without a done strobe.
    if (!io_bus.enable) begin
      w_next_state = ST_IDLE;
      w_next_cnt   = '0;
    end

    if (w_next_state == ST_DRIVE) begin
      w_next_dec[w_next_code] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_code    <= '0;
      r_dec_out <= '0;
    end else begin
      r_state   <= w_next_state;
      r_cnt     <= w_next_cnt;
      r_code    <= w_next_code;
      r_dec_out <= w_next_dec;
    end
  end

  assign io_bus.dec_out  = r_dec_out;
  assign io_bus.in_ready = io_bus.enable && (r_state == ST_IDLE);
  assign io_bus.busy     = (r_state != ST_IDLE);
  assign io_bus.done     = (r_state == ST_DRIVE) && w_cnt_zero;

endmodule

// File: tb/tb_b13_anybit_dec.sv
// Directed bench for b13_anybit_dec: four instances cover the HOLD/GAP
// combinations (4/1, 2/0, 8/1, 1/0) with hand-computed expectations.
module tb_b13_anybit_dec;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  b13_anybit_dec_if #(.SEL_SIZE(4)) ifA ();
  b13_anybit_dec_if #(.SEL_SIZE(4)) ifB ();
  b13_anybit_dec_if #(.SEL_SIZE(4)) ifC ();
  b13_anybit_dec_if #(.SEL_SIZE(4)) ifD ();

  b13_anybit_dec #(.SEL_SIZE(4), .HOLD(4), .GAP(1)) dutA (.clk(clk), .rst(rst), .io_bus(ifA));
  b13_anybit_dec #(.SEL_SIZE(4), .HOLD(2), .GAP(0)) dutB (.clk(clk), .rst(rst), .io_bus(ifB));
  b13_anybit_dec #(.SEL_SIZE(4), .HOLD(8), .GAP(1)) dutC (.clk(clk), .rst(rst), .io_bus(ifC));
  b13_anybit_dec #(.SEL_SIZE(4), .HOLD(1), .GAP(0)) dutD (.clk(clk), .rst(rst), .io_bus(ifD));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge; inputs change and outputs are sampled there.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (ifA.dec_out !== 16'h0000) begin errors++; $display("[TB] FAIL reset_dec got %h want %h", ifA.dec_out, 16'h0000); end
    checks++; if (ifA.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", ifA.busy); end
    checks++; if (ifA.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", ifA.done); end
    checks++; if (ifA.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b want 1", ifA.in_ready); end
    step();
    rst = 1'b0;
    // Start a pulse with code 9 and hit reset in the middle of DRIVE.
    ifA.in_code = 4'd9; ifA.in_valid = 1'b1;
    step();
    ifA.in_valid = 1'b0;
    step();
    checks++; if (ifA.dec_out !== 16'h0200) begin errors++; $display("[TB] FAIL rst_pre_dec got %h want %h", ifA.dec_out, 16'h0200); end
    #2 rst = 1'b1;
    #1;
    checks++; if (ifA.dec_out !== 16'h0000) begin errors++; $display("[TB] FAIL rst_mid_dec got %h want %h", ifA.dec_out, 16'h0000); end
    checks++; if (ifA.busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_busy got %b want 0", ifA.busy); end
    checks++; if (ifA.done !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_done got %b want 0", ifA.done); end
    step();
    rst = 1'b0;
    #1;
    checks++; if (ifA.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_release_ready got %b want 1", ifA.in_ready); end
  endtask

  task automatic test_single();
    ifA.in_code = 4'd5; ifA.in_valid = 1'b1;
    checks++; if (ifA.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_ready0 got %b want 1", ifA.in_ready); end
    step();
    ifA.in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      checks++; if (ifA.dec_out !== 16'h0020) begin errors++; $display("[TB] FAIL single_dec c%0d got %h want %h", k, ifA.dec_out, 16'h0020); end
      checks++; if (ifA.done !== (k == 4)) begin errors++; $display("[TB] FAIL single_done c%0d got %b want %b", k, ifA.done, (k == 4)); end
      checks++; if (ifA.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL single_ready c%0d got %b want 0", k, ifA.in_ready); end
      step();
    end
    checks++; if (ifA.dec_out !== 16'h0000) begin errors++; $display("[TB] FAIL single_gap_dec got %h want %h", ifA.dec_out, 16'h0000); end
    checks++; if (ifA.busy !== 1'b1) begin errors++; $display("[TB] FAIL single_gap_busy got %b want 1", ifA.busy); end
    checks++; if (ifA.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL single_gap_ready got %b want 0", ifA.in_ready); end
    step();
    checks++; if (ifA.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_ready6 got %b want 1", ifA.in_ready); end
    checks++; if (ifA.busy !== 1'b0) begin errors++; $display("[TB] FAIL single_busy6 got %b want 0", ifA.busy); end
  endtask

  task automatic test_sweep();
    logic [15:0] expected;
    bit          ready_seen;
    for (int c = 0; c < 16; c++) begin
      expected = 16'h0001 << c;
      ifA.in_code = 4'(c); ifA.in_valid = 1'b1;
      step();
      ifA.in_valid = 1'b0;
      checks++; if (ifA.dec_out !== expected) begin errors++; $display("[TB] FAIL sweep_dec code %0d got %h want %h", c, ifA.dec_out, expected); end
      checks++; if ($countones(ifA.dec_out) != 1) begin errors++; $display("[TB] FAIL sweep_onehot code %0d got %0d bits want 1", c, $countones(ifA.dec_out)); end
      ready_seen = 1'b0;
      for (int t = 0; t < 20 && !ready_seen; t++) begin
        step();
        ready_seen = ifA.in_ready;
      end
      checks++; if (!ready_seen) begin errors++; $display("[TB] FAIL sweep_timeout code %0d got ready 0 want 1", c); end
    end
  endtask

  task automatic test_back_to_back();
    ifB.in_code = 4'd3; ifB.in_valid = 1'b1;
    step();
    ifB.in_code = 4'd7;
    for (int k = 1; k <= 2; k++) begin
      checks++; if (ifB.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ready c%0d got %b want 0", k, ifB.in_ready); end
      checks++; if (ifB.dec_out !== 16'h0008) begin errors++; $display("[TB] FAIL b2b_dec3 c%0d got %h want %h", k, ifB.dec_out, 16'h0008); end
      step();
    end
    checks++; if (ifB.dec_out !== 16'h0000) begin errors++; $display("[TB] FAIL b2b_idle_dec got %h want %h", ifB.dec_out, 16'h0000); end
    checks++; if (ifB.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready3 got %b want 1", ifB.in_ready); end
    step();
    ifB.in_valid = 1'b0;
    for (int k = 4; k <= 5; k++) begin
      checks++; if (ifB.dec_out !== 16'h0080) begin errors++; $display("[TB] FAIL b2b_dec7 c%0d got %h want %h", k, ifB.dec_out, 16'h0080); end
      checks++; if (ifB.done !== (k == 5)) begin errors++; $display("[TB] FAIL b2b_done c%0d got %b want %b", k, ifB.done, (k == 5)); end
      step();
    end
    checks++; if (ifB.dec_out !== 16'h0000) begin errors++; $display("[TB] FAIL b2b_end_dec got %h want %h", ifB.dec_out, 16'h0000); end
  endtask

  task automatic test_abort();
    int hi_cycles;
    int done_cycles;
    ifC.in_code = 4'd2; ifC.in_valid = 1'b1;
    step();
    ifC.in_valid = 1'b0;
    step();
    step();
    ifC.enable = 1'b0;
    #1;
    checks++; if (ifC.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL abort_ready got %b want 0", ifC.in_ready); end
    checks++; if (ifC.dec_out !== 16'h0004) begin errors++; $display("[TB] FAIL abort_dec3 got %h want %h", ifC.dec_out, 16'h0004); end
    step();
    checks++; if (ifC.dec_out !== 16'h0000) begin errors++; $display("[TB] FAIL abort_dec4 got %h want %h", ifC.dec_out, 16'h0000); end
    checks++; if (ifC.busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy got %b want 0", ifC.busy); end
    checks++; if (ifC.done !== 1'b0) begin errors++; $display("[TB] FAIL abort_done got %b want 0", ifC.done); end
    ifC.enable = 1'b1; ifC.in_code = 4'd1; ifC.in_valid = 1'b1;
    step();
    ifC.in_valid = 1'b0;
    hi_cycles = 0; done_cycles = 0;
    for (int t = 0; t < 12; t++) begin
      if (ifC.dec_out === 16'h0002) hi_cycles++;
      if (ifC.done === 1'b1) done_cycles++;
      step();
    end
    checks++; if (hi_cycles != 8) begin errors++; $display("[TB] FAIL abort_rerun_width got %0d want 8", hi_cycles); end
    checks++; if (done_cycles != 1) begin errors++; $display("[TB] FAIL abort_rerun_done got %0d want 1", done_cycles); end
  endtask

  task automatic test_min_hold();
    ifD.in_code = 4'd12; ifD.in_valid = 1'b1;
    step();
    ifD.in_valid = 1'b0;
    checks++; if (ifD.dec_out !== 16'h1000) begin errors++; $display("[TB] FAIL min_dec got %h want %h", ifD.dec_out, 16'h1000); end
    checks++; if (ifD.done !== 1'b1) begin errors++; $display("[TB] FAIL min_done got %b want 1", ifD.done); end
    step();
    checks++; if (ifD.dec_out !== 16'h0000) begin errors++; $display("[TB] FAIL min_dec_after got %h want %h", ifD.dec_out, 16'h0000); end
    checks++; if (ifD.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL min_ready got %b want 1", ifD.in_ready); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    ifA.enable = 1'b1; ifA.in_valid = 1'b0; ifA.in_code = '0;
    ifB.enable = 1'b1; ifB.in_valid = 1'b0; ifB.in_code = '0;
    ifC.enable = 1'b1; ifC.in_valid = 1'b0; ifC.in_code = '0;
    ifD.enable = 1'b1; ifD.in_valid = 1'b0; ifD.in_code = '0;
    #2;
    test_reset();
    test_single();
    test_sweep();
    test_back_to_back();
    test_abort();
    test_min_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
